// File: rtl/i2c_arbiter.sv
// ---------------------------------------------------------------------------
// i2c_arbiter
// Round-robin arbiter that lets two requesters share one I2C byte master.
// A granted command is latched, issued to the master (START/WAIT/STOP),
// retried with a repeated start on NACK, bounded by a per-attempt timeout,
// and completed with a one-cycle doneN pulse plus status/rdata.
//
// Ports
//   clk, reset            : clock, synchronous active-low reset
//   reqN/rwN/addrN/regN/wdataN (N=0,1) : requester command, req held to doneN
//   doneN                 : one-cycle completion pulse to requester N
//   status                : 00 OK, 01 NACK, 10 TIMEOUT (valid with doneN)
//   rdata                 : read data, held until the next completion
//   busy                  : transaction in progress
//   m_en/m_start/m_stop   : master enable and start/stop strobes
//   m_mode/m_addr/m_reg/m_wdata : latched command fields to the master
//   m_done/m_ack/m_rdata  : master attempt completion, ACK and read data
// ---------------------------------------------------------------------------
module i2c_arbiter #(
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int RETRY_MAX      = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req0,
   input  logic       rw0,
   input  logic [6:0] addr0,
   input  logic [7:0] reg0,
   input  logic [7:0] wdata0,
   input  logic       req1,
   input  logic       rw1,
   input  logic [6:0] addr1,
   input  logic [7:0] reg1,
   input  logic [7:0] wdata1,
   output logic       done0,
   output logic       done1,
   output logic [1:0] status,
   output logic [7:0] rdata,
   output logic       busy,
   output logic       m_en,
   output logic       m_start,
   output logic       m_stop,
   output logic       m_mode,
   output logic [6:0] m_addr,
   output logic [7:0] m_reg,
   output logic [7:0] m_wdata,
   input  logic       m_done,
   input  logic       m_ack,
   input  logic [7:0] m_rdata
);

   typedef enum logic [2:0] {IDLE, START, WAIT, STOP, RESP} state_t;

   localparam logic [15:0] TLAST = 16'(TIMEOUT_CYCLES - 1);
   localparam logic [1:0]  RMAX  = 2'(RETRY_MAX);

   state_t      state, state_nxt;
   logic        grant, grant_nxt;   // requester owning the current transaction
   logic        last, last_nxt;     // requester served most recently
   logic [15:0] timer, timer_nxt;
   logic [1:0]  retry, retry_nxt;
   logic [1:0]  status_nxt;
   logic [7:0]  rdata_nxt;
   logic        mode_nxt;
   logic [6:0]  addr_nxt;
   logic [7:0]  reg_nxt, wdata_nxt;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state   <= IDLE;
         grant   <= 1'b0;
         last    <= 1'b1;          // "1 served last" gives requester 0 priority
         timer   <= '0;
         retry   <= '0;
         status  <= 2'b00;
         rdata   <= 8'h00;
         m_mode  <= 1'b0;
         m_addr  <= '0;
         m_reg   <= '0;
         m_wdata <= '0;
      end else begin
         state   <= state_nxt;
         grant   <= grant_nxt;
         last    <= last_nxt;
         timer   <= timer_nxt;
         retry   <= retry_nxt;
         status  <= status_nxt;
         rdata   <= rdata_nxt;
         m_mode  <= mode_nxt;
         m_addr  <= addr_nxt;
         m_reg   <= reg_nxt;
         m_wdata <= wdata_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      grant_nxt  = grant;
      last_nxt   = last;
      timer_nxt  = timer;
      retry_nxt  = retry;
      status_nxt = status;
      rdata_nxt  = rdata;
      mode_nxt   = m_mode;
      addr_nxt   = m_addr;
      reg_nxt    = m_reg;
      wdata_nxt  = m_wdata;
      case (state)
         IDLE: begin
            if (req0 || req1) begin
               // Contention goes to whoever was not served last.
               grant_nxt = (req0 && req1) ? ~last : req1;
               mode_nxt  = grant_nxt ? rw1    : rw0;
               addr_nxt  = grant_nxt ? addr1  : addr0;
               reg_nxt   = grant_nxt ? reg1   : reg0;
               wdata_nxt = grant_nxt ? wdata1 : wdata0;
               retry_nxt = '0;
               state_nxt = START;
            end
         end
         START: begin
            timer_nxt = '0;
            state_nxt = WAIT;
         end
         WAIT: begin
            timer_nxt = timer + 16'd1;
            // m_done is checked first so it wins over a coincident timeout.
            if (m_done) begin
               if (m_ack) begin
                  if (m_mode) rdata_nxt = m_rdata;
                  status_nxt = 2'b00;
                  state_nxt  = STOP;
               end else if (retry < RMAX) begin
                  retry_nxt = retry + 2'd1;
                  state_nxt = START;   // repeated start, bus not released
               end else begin
                  status_nxt = 2'b01;
                  state_nxt  = STOP;
               end
            end else if (timer == TLAST) begin
               status_nxt = 2'b10;
               state_nxt  = STOP;
            end
         end
         STOP: state_nxt = RESP;
         RESP: begin
            last_nxt  = grant;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign busy    = (state != IDLE);
   assign m_en    = (state == START) || (state == WAIT) || (state == STOP);
   assign m_start = (state == START);
   assign m_stop  = (state == STOP);
   assign done0   = (state == RESP) && !grant;
   assign done1   = (state == RESP) &&  grant;

endmodule
